shift_add_multiplier_4bit: RTL and testbench



---
 rtl/shift_add_multiplier_4bit.sv | 157 +++++++++++++++
 tb/tb_shift_add_multiplier_4bit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier_4bit.sv
// shift_add_multiplier_4bit: sequential 4x4 unsigned shift-and-add multiplier
// with a start/busy/done handshake. The per-iteration partial-sum add uses a
// 4-bit ripple adder (Four_Bit_Adder_Struc) for both its sum and carry-out.
// Optional feature macro: ZERO_SKIP_EN. When it is defined, a zero operand
// goes straight to DONE with a zero product.

// Four_Bit_Adder_Struc: 4-bit ripple-carry adder built from full-adder cells.
module Four_Bit_Adder_Struc (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_c,
    output logic       cout_c
);
    localparam int unsigned W = 4;

    logic [W:0] carry;

    assign carry[0] = cin_i;

    // One full-adder cell per bit, carry rippling upward.
    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum_c[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_c = carry[W];
endmodule

module shift_add_multiplier_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] p
);
    localparam int unsigned OPW  = 4;
    localparam int unsigned PW   = 8;
    localparam int unsigned CNTW = 3;
    localparam logic [CNTW-1:0] LAST_ITER = CNTW'(3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [OPW-1:0]  m_q, m_d;
    logic [OPW-1:0]  a_q, a_d;
    logic [OPW-1:0]  q_q, q_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [PW-1:0]   p_q, p_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [OPW-1:0]  add_sum_c;
    logic            add_cout_c;
    logic [OPW-1:0]  part_a_c;
    logic            part_c_c;

    // Partial-sum adder: A + M, carry kept for the shift into A[3].
    Four_Bit_Adder_Struc u_adder (
        .a_i    (a_q),
        .b_i    (m_q),
        .cin_i  (1'b0),
        .sum_c  (add_sum_c),
        .cout_c (add_cout_c)
    );

    // Select {C,A}: added partial when the current multiplier bit is set.
    always_comb begin
        part_a_c = a_q;
        part_c_c = 1'b0;
        if (q_q[0]) begin
            part_a_c = add_sum_c;
            part_c_c = add_cout_c;
        end
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    a_d     = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
`ifdef ZERO_SKIP_EN
                    if ((a == '0) || (b == '0)) begin
                        state_d = S_DONE;
                        p_d     = '0;
                    end
`endif
                end
            end
            S_CALC: begin
                // Right shift of {C,A,Q}: carry enters A[3], A[0] enters Q[3].
                a_d   = {part_c_c, part_a_c[OPW-1:1]};
                q_d   = {part_a_c[0], q_q[OPW-1:1]};
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                    p_d     = {a_d, q_d};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;
endmodule

// File: tb/tb_shift_add_multiplier_4bit.sv
// Scoreboard bench for shift_add_multiplier_4bit: stimulus pushes expected
// product and due cycle; a negedge monitor pops on every done pulse.
module tb_shift_add_multiplier_4bit;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] p;

    typedef struct {
        logic [7:0] prod;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    logic prev_done = 1'b0;

    shift_add_multiplier_4bit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Edges from the accepting edge to the edge that raises done.
    function automatic int lat_for(input logic [3:0] x, input logic [3:0] y);
`ifdef ZERO_SKIP_EN
        if ((x == 4'd0) || (y == 4'd0)) return 0;
`endif
        return 4;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            chk("done_width", int'(prev_done), 0);
            chk("busy_with_done", int'(busy), 1);
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("product", int'(p), int'(e.prod));
                chk("done_cycle", cyc, e.due);
            end
        end
        prev_done = done;
    end

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 20 && busy; i++) @(negedge clk);
        if (busy) chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic do_mult(input logic [3:0] x, input logic [3:0] y, input logic [7:0] e);
        exp_t ex;
        @(negedge clk);
        start = 1'b1; a = x; b = y;
        @(posedge clk);
        #1;
        ex.prod = e;
        ex.due  = cyc + lat_for(x, y);
        sb.push_back(ex);
        @(negedge clk);
        start = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
        wait_idle("mult");
        chk("p_hold", int'(p), int'(e));
    endtask

    initial begin
        exp_t ex;
        int   c0;
        rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_p", int'(p), 0);
        rst = 1'b0;

        // Directed products.
        do_mult(4'd13, 4'd4,  8'h34);
        do_mult(4'd7,  4'd2,  8'h0E);
        do_mult(4'd9,  4'd15, 8'h87);
        do_mult(4'd15, 4'd9,  8'h87);
        do_mult(4'd15, 4'd15, 8'hE1);
        do_mult(4'd1,  4'd1,  8'h01);

        // Zero operands.
        do_mult(4'd0,  4'd9,  8'h00);
        do_mult(4'd12, 4'd0,  8'h00);

        // Start while busy: 5*3 with start pulses on cycles 2 and 4.
        @(negedge clk);
        start = 1'b1; a = 4'd5; b = 4'd3;
        @(posedge clk);
        #1;
        ex.prod = 8'h0F; ex.due = cyc + 4;
        sb.push_back(ex);
        @(negedge clk); start = 1'b0; a = 4'd2; b = 4'd2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_idle("busy_start");
        chk("busy_start_p", int'(p), 8'h0F);
        repeat (3) @(negedge clk);
        chk("busy_start_not_queued", int'(busy), 0);

        // Reset in the middle of 11*11: no done may follow.
        @(negedge clk);
        start = 1'b1; a = 4'd11; b = 4'd11;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_p", int'(p), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_idle", int'(busy), 0);
        do_mult(4'd3, 4'd6, 8'h12);

        // Continuous start with 6*7: one product every 6 cycles.
        @(negedge clk);
        start = 1'b1; a = 4'd6; b = 4'd7;
        @(posedge clk);
        #1;
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            ex.prod = 8'h2A; ex.due = c0 + 4 + 6 * k;
            sb.push_back(ex);
        end
        repeat (18) @(negedge clk);
        start = 1'b0;
        wait_idle("continuous");
        repeat (2) @(negedge clk);
        chk("continuous_stopped", int'(busy), 0);

        // Exhaustive sweep against a behavioural product.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                do_mult(4'(i), 4'(j), 8'(i * j));
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
